// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one registered add/subtract unit among NREQ requesters.
// One operation is in flight at a time. The result is returned as a one-cycle pulse
// to the requester that issued it.
module addsub_rr_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned LAT  = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NREQ-1:0]                   req_valid,
   input  logic [NREQ*W-1:0]                 req_a,
   input  logic [NREQ*W-1:0]                 req_b,
   input  logic [NREQ-1:0]                   req_sub,
   output logic [NREQ-1:0]                   req_ready,
   output logic [W-1:0]                      dp_in1,
   output logic [W-1:0]                      dp_in2,
   output logic                              dp_sub,
   input  logic [W-1:0]                      dp_out,
   output logic [NREQ-1:0]                   rsp_valid,
   output logic [$clog2(NREQ)-1:0]           rsp_id,
   output logic [W-1:0]                      rsp_data,
   output logic                              busy
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam logic [2:0] LatCnt = 3'(LAT);

   typedef enum logic [0:0] {StIdle, StBusy} state_t;

   state_t        state;
   logic [IW-1:0] last;     // most recent grant; also identifies the in-flight requester
   logic [IW-1:0] winner;
   logic          any_req;
   logic [2:0]    cnt;

   // Round-robin pick: first pending requester scanning upward from last+1.
   always_comb begin
      winner  = last;
      any_req = 1'b0;
      for (int i = 1; i <= int'(NREQ); i++) begin
         int idx;
         idx = (int'(last) + i) % int'(NREQ);
         if (!any_req && req_valid[idx[IW-1:0]]) begin
            any_req = 1'b1;
            winner  = idx[IW-1:0];
         end
      end
   end

   // One-hot accept, offered only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (!rst && state == StIdle && any_req) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Busy spans from acceptance to the cycle before the response pulse.
   always_comb begin
      busy = (state == StBusy);
   end

   // Scheduler FSM with registered datapath operands and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         last      <= IW'(NREQ - 1);
         cnt       <= '0;
         dp_in1    <= '0;
         dp_in2    <= '0;
         dp_sub    <= 1'b0;
         rsp_valid <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= '0;
         unique case (state)
            StIdle: begin
               if (any_req) begin
                  dp_in1 <= req_a[int'(winner)*int'(W) +: W];
                  dp_in2 <= req_b[int'(winner)*int'(W) +: W];
                  dp_sub <= req_sub[winner];
                  last   <= winner;
                  cnt    <= LatCnt;
                  state  <= StBusy;
               end
            end
            StBusy: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  // Operands are still held, so dp_out is settled for this request.
                  rsp_data        <= dp_out;
                  rsp_id          <= last;
                  rsp_valid[last] <= 1'b1;
                  state           <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/addsub_rr_scheduler.md
# addsub_rr_scheduler

Round-robin scheduler that shares one registered 8-bit add/subtract datapath among `NREQ` requesters. It accepts one request at a time and drives the shared unit's operand bus (`in1`/`in2`/`rst`-style clocked interface). After the unit's fixed latency it samples the result and returns it to the granted requester with a one-cycle response pulse. It sits between the requester agents and the single shared arithmetic unit.

## Interface
- Clocking: one clock, `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `NREQ`, 4: number of requesters, 2..8
- `W`, 8: operand/result width
- `LAT`, 1: shared-unit latency in cycles, from operands applied to `dp_out` valid; range 0..7

Ports:
- `clk`  in  1  clock, all logic on posedge
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  NREQ  request pending, per requester
- `req_a`  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- `req_b`  in  NREQ*W  operand B, same packing
- `req_sub`  in  NREQ  1 = subtract (A-B), 0 = add
- `req_ready`  out  NREQ  one-hot accept; the handshake completes on valid&ready
- `dp_in1`  out  W  shared unit operand 1 (registered)
- `dp_in2`  out  W  shared unit operand 2 (registered)
- `dp_sub`  out  1  shared unit op select (registered)
- `dp_out`  in  W  shared unit result
- `rsp_valid`  out  NREQ  one-hot, one-cycle result pulse (registered)
- `rsp_id`  out  $clog2(NREQ)  index of the responding requester (registered)
- `rsp_data`  out  W  sampled `dp_out` (registered)
- `busy`  out  1  high from acceptance until the cycle before `rsp_valid`

## Operation
FSM states:
- **IDLE**
  - If any `req_valid` is set, the winner is the first set bit scanning from `last+1` modulo NREQ.
  - `req_ready[winner]` is asserted combinationally in this cycle. The block registers `req_a`/`req_b`/`req_sub` of the winner into `dp_in1`/`dp_in2`/`dp_sub`, sets `last <= winner` and `cnt <= LAT`, and moves to BUSY.
  - If no `req_valid` is set, it stays in IDLE.
- **BUSY**
  - `req_ready` is all zero.
  - If `cnt != 0`: `cnt` decrements.
  - If `cnt == 0`: `rsp_data <= dp_out`, `rsp_id <= winner`, `rsp_valid[winner] <= 1`, and the FSM moves to IDLE.

Rules:
- `req_ready` is only ever asserted in IDLE and is never multi-hot.
- Requesters hold `req_valid` and operands stable until accepted. Behaviour on retraction before acceptance is undefined; the bench flags it.
- `dp_in1`/`dp_in2`/`dp_sub` hold their values after the response until the next acceptance (no toggling while idle).
- `rsp_valid` is a single-cycle pulse.
- Arithmetic and wrap-around are owned by the shared unit. The block passes `W`-bit values unmodified, with no width extension or truncation.
- Fairness: a continuously asserted requester waits at most NREQ-1 grants.

Reset values (next edge after `rst` = 1):
- State = IDLE, `last` = NREQ-1 (requester 0 has first priority), `cnt` = 0.
- `dp_in1` = 0, `dp_in2` = 0, `dp_sub` = 0.
- `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `busy` = 0.
- `req_ready` = 0 while `rst` is high.

Reset mid-operation: the in-flight operation is abandoned, no `rsp_valid` is emitted for it, and the requester must re-request.

## Timing
- Accept in cycle t, meaning `req_valid[i]` and `req_ready[i]` are both high at edge t.
- `dp_in1`/`dp_in2` are valid from cycle t+1.
- `dp_out` is sampled in cycle t+1+LAT.
- `rsp_valid[i]` is high in cycle t+2+LAT only.
- `busy` is high in cycles t+1 .. t+1+LAT.
- The FSM is in IDLE in cycle t+2+LAT, so the next acceptance can coincide with the `rsp_valid` cycle. Back-to-back issue interval is LAT+2 cycles.
- When a response and a new `req_valid` from the same requester land in the same cycle, that requester is eligible under round-robin order. Its previous grant makes it lowest priority.

## Test plan
- Single add, LAT=1:
  - Stimulus: req 2 with a=8'd100, b=8'd27, sub=0, accepted at cycle 5.
  - Required: `dp_in1`=100, `dp_in2`=27 at cycle 6; `rsp_valid`=4'b0100, `rsp_id`=2, `rsp_data`=127 at cycle 8.
- Subtract wrap:
  - Stimulus: req 0 with a=8'd5, b=8'd9, sub=1, model unit computes A-B mod 256.
  - Required: `rsp_data`=8'd252, `rsp_id`=0.
- Round-robin, all four `req_valid` held high from reset:
  - Required: grants in order 0,1,2,3,0 at intervals of LAT+2 = 3 cycles; `req_ready` is one-hot each time.
- Priority after grant:
  - Stimulus: only req 1 active, then req 1 and req 3 request together in the `rsp_valid` cycle.
  - Required: req 3 is granted first.
- Reset mid-op:
  - Stimulus: assert `rst` for 1 cycle at t+1 after accepting req 1.
  - Required: no `rsp_valid` ever appears for it; all outputs reach reset values at the next edge; a subsequent request from req 0 is granted first.
- LAT=0 and LAT=7 variants:
  - Required: `rsp_valid` at t+2 and t+9 respectively; `busy` high for exactly LAT+1 cycles.
